regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5: address width; depth SHALL be 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2: number of independent read ports, range 1..4.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 rd_addr  in  NUM_RD x ADDR_W  read address per port.
REQ-008 rd_data  out  NUM_RD x DATA_W  read data per port.
REQ-009 rd_busy  out  NUM_RD  pending-write flag of the addressed register per port.
REQ-010 wr_en  in  1  write strobe.
REQ-011 wr_addr  in  ADDR_W  write address.
REQ-012 wr_data  in  DATA_W  write data.
REQ-013 wr_be  in  DATA_W/8  byte enables; a byte is written only when its bit is 1.
REQ-014 rsv_en  in  1  reservation strobe; marks a register as awaiting writeback.
REQ-015 rsv_addr  in  ADDR_W  register to reserve.
REQ-016 busy_cnt  out  ADDR_W+1  count of currently reserved registers.

Function
REQ-017 Reads SHALL be combinational from rd_addr, with zero-cycle latency.
REQ-018 Write bypass: when wr_en=1 and wr_addr==rd_addr[i], rd_data[i] SHALL show the stored word with the enabled bytes replaced by wr_data in the same cycle.
REQ-019 The register SHALL update on the next rising clk edge with its enabled bytes only; disabled bytes SHALL keep their value.
REQ-020 wr_en=1 with wr_be all zero SHALL change neither any register nor any busy bit.
REQ-021 A per-register busy bit SHALL be set on the edge where rsv_en=1 for that address.
REQ-022 A busy bit SHALL be cleared on the edge where wr_en=1, wr_be is not zero, and wr_addr matches that register.
REQ-023 Reserve and write to the same address in one cycle: the busy bit SHALL end set, because the new reservation wins.
REQ-024 Reserve and write to different addresses in one cycle: both actions SHALL take effect.
REQ-025 Reserving an already busy register SHALL leave it busy and SHALL NOT change busy_cnt.
REQ-026 rd_busy[i] SHALL equal the busy bit of rd_addr[i], except it SHALL read 0 when a clearing write to that address is present in the same cycle and no same-address reservation is present.
REQ-027 busy_cnt SHALL be a registered count equal to the number of set busy bits after each edge.
REQ-028 busy_cnt SHALL change by +1, -1 or 0 per cycle, never wrap, and saturate naturally at 2**ADDR_W.
REQ-029 When ZERO_REG=1, address 0 SHALL read 0 and show rd_busy 0.
REQ-030 When ZERO_REG=1, writes and reservations to address 0 SHALL be ignored, including for bypass and busy_cnt.
REQ-031 When ZERO_REG=0, register 0 SHALL behave like every other register.
REQ-032 Out-of-range addresses cannot occur, since depth = 2**ADDR_W.

Reset
REQ-033 reset=1 SHALL clear all registers, all busy bits and busy_cnt to 0, independent of clk.
REQ-034 During reset, rd_data SHALL read 0 and rd_busy SHALL read 0, regardless of wr_en bypass.
REQ-035 A write or reservation whose clock edge coincides with reset asserted SHALL be lost.
REQ-036 The first write after reset deasserts SHALL occur on the first rising edge with reset=0.

Structure
REQ-037 The shared package regfile_pkg SHALL hold the default constants DATA_W_DEF, ADDR_W_DEF and NUM_RD_DEF, plus a function computing the byte-merge of a word, data and byte enables.
REQ-038 A single sub-module regfile_rdport (one read port: mux, bypass merge, busy lookup) SHALL be instantiated NUM_RD times in a generate loop.
REQ-039 Storage and busy bits SHALL be flop arrays; no memory macros SHALL be inferred.

Verification
REQ-040 Reset, then write 0xDEADBEEF to r5 with be=1111 -> rd_data=0xDEADBEEF on the write cycle (bypass) and on the next cycle.
REQ-041 With r5=0xDEADBEEF, write 0x00001234 with be=0011 -> r5 reads 0xDEAD1234.
REQ-042 With ZERO_REG=1, write 0xFFFFFFFF to r0 and reserve r0 -> r0 reads 0, rd_busy=0, busy_cnt=0.
REQ-043 Reserve r3, then r7, then r3 again -> busy_cnt goes 1, 2, 2; write r3 -> rd_busy for r3 reads 0 in that cycle and busy_cnt=1 after the edge.
REQ-044 Same-cycle reserve r9 and write r9 while r9 is busy -> r9 stays busy, busy_cnt unchanged, data updated.
REQ-045 Assert reset mid-operation with 4 registers busy and r2=0x55 -> busy_cnt=0, all rd_busy=0 and r2=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and the byte-merge helper for the register-file scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MERGE_W  = 256;
  localparam int MERGE_BE = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]  word,
    input logic [MERGE_W-1:0]  data,
    input logic [MERGE_BE-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = word;
    for (int b = 0; b < MERGE_BE; b++) begin
      if (be[b]) res[b*8 +: 8] = data[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Bundle of read ports, write port, reservation port and busy count.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) ();

  // Handshake: wr_en and rsv_en are single-cycle qualifiers sampled on the
  // rising clk edge; there is no back-pressure, every strobe is accepted.
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]             rd_busy;
  logic                          wr_en;
  logic [ADDR_W-1:0]             wr_addr;
  logic [DATA_W-1:0]             wr_data;
  logic [DATA_W/8-1:0]           wr_be;
  logic                          rsv_en;
  logic [ADDR_W-1:0]             rsv_addr;
  logic [ADDR_W:0]               busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_be, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_be, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_cnt
  );

endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: register mux, same-cycle write bypass, busy lookup.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                                reset,
  input  logic [ADDR_W-1:0]                   rd_addr_i,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    regs_i,
  input  logic [2**ADDR_W-1:0]                busy_i,
  input  logic                                wr_ok_i,
  input  logic [ADDR_W-1:0]                   wr_addr_i,
  input  logic [DATA_W-1:0]                   wr_data_i,
  input  logic [DATA_W/8-1:0]                 wr_be_i,
  input  logic                                rsv_ok_i,
  input  logic [ADDR_W-1:0]                   rsv_addr_i,
  output logic [DATA_W-1:0]                   rd_data_o,
  output logic                                rd_busy_o
);

  logic wr_hit;
  logic rsv_hit;

  assign wr_hit  = wr_ok_i && (wr_addr_i == rd_addr_i);
  assign rsv_hit = rsv_ok_i && (rsv_addr_i == rd_addr_i);

  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
    rd_busy_o = busy_i[rd_addr_i] && !(wr_hit && !rsv_hit);
    if (wr_hit) begin
      rd_data_o = DATA_W'(byte_merge(MERGE_W'(regs_i[rd_addr_i]),
                                     MERGE_W'(wr_data_i),
                                     MERGE_BE'(wr_be_i)));
    end
    // Reset masks the bypass path too, not only the stored word.
    if (reset || ((ZERO_REG != 0) && (rd_addr_i == '0))) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-writeback bits and a registered busy count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic     clk,
  input  logic     reset,
  regfile_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic [ADDR_W:0]              busy_cnt_q, busy_cnt_d;

  logic wr_ok;
  logic rsv_ok;
  logic cnt_inc;
  logic cnt_dec;

  // A write with no enabled byte is a no-op; register 0 may be hardwired.
  assign wr_ok  = bus.wr_en && (|bus.wr_be) &&
                  !((ZERO_REG != 0) && (bus.wr_addr == '0));
  assign rsv_ok = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));

  assign cnt_inc = rsv_ok && !busy_q[bus.rsv_addr];
  assign cnt_dec = wr_ok && busy_q[bus.wr_addr] &&
                   !(rsv_ok && (bus.rsv_addr == bus.wr_addr));

  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    if (wr_ok) begin
      regs_d[bus.wr_addr] = DATA_W'(byte_merge(MERGE_W'(regs_q[bus.wr_addr]),
                                               MERGE_W'(bus.wr_data),
                                               MERGE_BE'(bus.wr_be)));
      busy_d[bus.wr_addr] = 1'b0;
    end
    // Applied after the clear so a same-address reservation wins.
    if (rsv_ok) busy_d[bus.rsv_addr] = 1'b1;
    if (cnt_inc && !cnt_dec) begin
      busy_cnt_d = busy_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    end else if (cnt_dec && !cnt_inc) begin
      busy_cnt_d = busy_cnt_q - {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q     <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .reset      (reset),
      .rd_addr_i  (bus.rd_addr[i]),
      .regs_i     (regs_q),
      .busy_i     (busy_q),
      .wr_ok_i    (wr_ok),
      .wr_addr_i  (bus.wr_addr),
      .wr_data_i  (bus.wr_data),
      .wr_be_i    (bus.wr_be),
      .rsv_ok_i   (rsv_ok),
      .rsv_addr_i (bus.rsv_addr),
      .rd_data_o  (bus.rd_data[i]),
      .rd_busy_o  (bus.rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a ZERO_REG=1 and a ZERO_REG=0 instance share stimulus.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          we, re;
  logic [AW-1:0] wa, ra, ra0, ra1;
  logic [DW-1:0] wd;
  logic [3:0]    be;

  regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus0 ();
  regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus1 ();

  assign bus0.wr_en    = we;
  assign bus0.wr_addr  = wa;
  assign bus0.wr_data  = wd;
  assign bus0.wr_be    = be;
  assign bus0.rsv_en   = re;
  assign bus0.rsv_addr = ra;
  assign bus0.rd_addr  = {ra1, ra0};
  assign bus1.wr_en    = we;
  assign bus1.wr_addr  = wa;
  assign bus1.wr_data  = wd;
  assign bus1.wr_be    = be;
  assign bus1.rsv_en   = re;
  assign bus1.rsv_addr = ra;
  assign bus1.rd_addr  = {ra1, ra0};

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) u_dut_zr (
    .clk   (clk),
    .reset (rst),
    .bus   (bus0)
  );

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) u_dut_nz (
    .clk   (clk),
    .reset (rst),
    .bus   (bus1)
  );

  // reference model: index 0 models ZERO_REG=1, index 1 models ZERO_REG=0
  logic [DW-1:0] m_mem  [2][DEPTH];
  bit            m_busy [2][DEPTH];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hard_zero(int d, logic [AW-1:0] a);
    return (d == 0) && (a == 0);
  endfunction

  function automatic logic [DW-1:0] apply_bytes(logic [DW-1:0] old_w, logic [DW-1:0] new_w,
                                                logic [3:0] en);
    logic [DW-1:0] mask;
    mask = {{8{en[3]}}, {8{en[2]}}, {8{en[1]}}, {8{en[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  function automatic logic [DW-1:0] exp_data(int d, logic [AW-1:0] a);
    if (rst || hard_zero(d, a)) return '0;
    if (we && (wa == a)) return apply_bytes(m_mem[d][a], wd, be);
    return m_mem[d][a];
  endfunction

  function automatic bit exp_busy(int d, logic [AW-1:0] a);
    bit clearing, reserving;
    if (rst || hard_zero(d, a)) return 1'b0;
    clearing  = we && (be != 0) && (wa == a);
    reserving = re && (ra == a);
    return m_busy[d][a] && !(clearing && !reserving);
  endfunction

  function automatic int exp_cnt(int d);
    int n = 0;
    for (int r = 0; r < DEPTH; r++) n += int'(m_busy[d][r]);
    return n;
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < DEPTH; r++) begin
        m_mem[d][r]  = '0;
        m_busy[d][r] = 1'b0;
      end
  endfunction

  function automatic void model_edge();
    if (rst) begin
      model_clear();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      if (we && (be != 0) && !hard_zero(d, wa)) begin
        m_mem[d][wa]  = apply_bytes(m_mem[d][wa], wd, be);
        m_busy[d][wa] = 1'b0;
      end
      if (re && !hard_zero(d, ra)) m_busy[d][ra] = 1'b1;
    end
  endfunction

  function automatic logic [DW-1:0] dut_data(int d, int p);
    return (d == 0) ? bus0.rd_data[p] : bus1.rd_data[p];
  endfunction

  function automatic logic dut_busy(int d, int p);
    return (d == 0) ? bus0.rd_busy[p] : bus1.rd_busy[p];
  endfunction

  function automatic logic [AW:0] dut_cnt(int d);
    return (d == 0) ? bus0.busy_cnt : bus1.busy_cnt;
  endfunction

  task automatic check_outputs();
    logic [AW-1:0] a;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NR; p++) begin
        a = (p == 0) ? ra0 : ra1;
        check($sformatf("rd_data d%0d p%0d a%0d", d, p, a), dut_data(d, p), exp_data(d, a));
        check($sformatf("rd_busy d%0d p%0d a%0d", d, p, a), 32'(dut_busy(d, p)),
              32'(exp_busy(d, a)));
      end
      check($sformatf("busy_cnt d%0d", d), 32'(dut_cnt(d)), 32'(exp_cnt(d)));
    end
  endtask

  // driver tasks
  task automatic drive(input logic w_en, input logic [AW-1:0] w_addr, input logic [DW-1:0] w_data,
                       input logic [3:0] w_be, input logic r_en, input logic [AW-1:0] r_addr,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    we = w_en; wa = w_addr; wd = w_data; be = w_be;
    re = r_en; ra = r_addr; ra0 = a0; ra1 = a1;
    #2;
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    we = 1'b0;
    re = 1'b0;
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b1;
    we = 1'b0; re = 1'b0; wa = '0; ra = '0; wd = '0; be = '0; ra0 = '0; ra1 = '0;
    model_clear();
    #3;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // full write, bypass on the write cycle, stored afterwards
    drive(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 5'd5, 5'd5);
    check("bypass_r5", bus0.rd_data[0], 32'hDEADBEEF);
    tick();
    check("stored_r5", bus0.rd_data[1], 32'hDEADBEEF);

    drive(1'b1, 5'd5, 32'h00001234, 4'h3, 1'b0, 5'd0, 5'd5, 5'd0);
    tick();
    check("partial_r5", bus0.rd_data[0], 32'hDEAD1234);

    drive(1'b1, 5'd5, 32'hFFFFFFFF, 4'h0, 1'b1, 5'd0, 5'd5, 5'd0);
    tick();
    check("be_zero_r5", bus0.rd_data[0], 32'hDEAD1234);

    // register 0: hardwired on bus0, ordinary on bus1
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd0, 5'd0, 5'd0);
    check("r0_bypass_zr", bus0.rd_data[0], 32'h0);
    tick();
    check("r0_data_zr", bus0.rd_data[0], 32'h0);
    check("r0_busy_zr", 32'(bus0.rd_busy[0]), 32'h0);
    check("r0_cnt_zr", 32'(bus0.busy_cnt), 32'd0);
    check("r0_data_nz", bus1.rd_data[0], 32'hFFFFFFFF);
    check("r0_busy_nz", 32'(bus1.rd_busy[0]), 32'h1);

    // reservation counting
    drive(1'b0, 5'd0, '0, 4'h0, 1'b1, 5'd3, 5'd3, 5'd7);
    tick();
    check("cnt_rsv_r3", 32'(bus0.busy_cnt), 32'd1);
    drive(1'b0, 5'd0, '0, 4'h0, 1'b1, 5'd7, 5'd3, 5'd7);
    tick();
    check("cnt_rsv_r7", 32'(bus0.busy_cnt), 32'd2);
    drive(1'b0, 5'd0, '0, 4'h0, 1'b1, 5'd3, 5'd3, 5'd7);
    tick();
    check("cnt_rsv_r3_again", 32'(bus0.busy_cnt), 32'd2);
    drive(1'b1, 5'd3, 32'h11112222, 4'hF, 1'b0, 5'd0, 5'd3, 5'd7);
    check("rd_busy_r3_clearing", 32'(bus0.rd_busy[0]), 32'h0);
    check("rd_busy_r7_held", 32'(bus0.rd_busy[1]), 32'h1);
    tick();
    check("cnt_after_wb_r3", 32'(bus0.busy_cnt), 32'd1);

    // same-cycle reserve and write on a busy register
    drive(1'b0, 5'd0, '0, 4'h0, 1'b1, 5'd9, 5'd9, 5'd7);
    tick();
    check("cnt_rsv_r9", 32'(bus0.busy_cnt), 32'd2);
    drive(1'b1, 5'd9, 32'hA5A5A5A5, 4'hF, 1'b1, 5'd9, 5'd9, 5'd7);
    check("rd_busy_r9_rsv_wins", 32'(bus0.rd_busy[0]), 32'h1);
    tick();
    check("busy_r9_kept", 32'(bus0.rd_busy[0]), 32'h1);
    check("cnt_r9_kept", 32'(bus0.busy_cnt), 32'd2);
    check("data_r9", bus0.rd_data[0], 32'hA5A5A5A5);

    // four busy registers, then asynchronous reset between edges
    drive(1'b1, 5'd2, 32'h00000055, 4'hF, 1'b1, 5'd2, 5'd2, 5'd7);
    tick();
    drive(1'b0, 5'd0, '0, 4'h0, 1'b1, 5'd10, 5'd2, 5'd7);
    tick();
    check("cnt_four_busy", 32'(bus0.busy_cnt), 32'd4);
    check("r2_before_reset", bus0.rd_data[0], 32'h55);
    we = 1'b1; wa = 5'd2; wd = 32'hFFFFFFFF; be = 4'hF;
    #1;
    rst = 1'b1;
    model_clear();
    #1;
    check("async_cnt", 32'(bus0.busy_cnt), 32'd0);
    check("async_busy_p0", 32'(bus0.rd_busy[0]), 32'h0);
    check("async_busy_p1", 32'(bus0.rd_busy[1]), 32'h0);
    check("async_r2_bypass_masked", bus0.rd_data[0], 32'h0);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    we = 1'b0;
    rst = 1'b0;
    #1;
    check("r2_write_lost", bus0.rd_data[0], 32'h0);
    check_outputs();

    // randomized traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] r_wa, r_ra, r_a0, r_a1;
      bool_rst: begin
        r_wa = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
        r_ra = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
        r_a0 = ($urandom_range(0, 9) < 3) ? r_wa : AW'($urandom_range(0, 31));
        r_a1 = ($urandom_range(0, 9) < 3) ? r_ra : AW'($urandom_range(0, 7));
        if ($urandom_range(0, 99) < 2) begin
          rst = 1'b1;
          model_clear();
        end
        drive(1'($urandom_range(0, 1)), r_wa, DW'($urandom), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 9) < 4), r_ra, r_a0, r_a1);
        tick();
        if (rst) begin
          rst = 1'b0;
          #1;
          check_outputs();
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
